// File: rtl/formula_result_buffer_pkg.sv
// Shared sizing helpers for the credit-gated result buffer and its FIFO.
package formula_result_buffer_pkg;

  // Pointer carries one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/formula_result_buffer_if.sv
// Handshake bundle between source, formula pipeline, consumer and the result buffer.
interface formula_result_buffer_if #(
  parameter int WIDTH = 32
) ();
  import formula_result_buffer_pkg::*;

  logic             in_vld;
  logic             in_rdy;
  logic             arg_vld;
  logic             res_vld;
  logic [WIDTH-1:0] res;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;
  logic             overflow;

  modport master (
    output in_vld, res_vld, res, out_rdy,
    input  in_rdy, arg_vld, out_vld, out_data, overflow
  );

  modport slave (
    input  in_vld, res_vld, res, out_rdy,
    output in_rdy, arg_vld, out_vld, out_data, overflow
  );

endinterface

// File: rtl/formula_result_buffer_result_fifo.sv
// Result FIFO with wrap-bit pointers; a write into a full FIFO is only taken
// when the head is popped in the same cycle, otherwise it is dropped and flagged.
module result_fifo
  import formula_result_buffer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic empty;
  logic full;
  logic pop;
  logic wr_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop   = rd_en_i & ~empty;
  assign wr_ok = wr_en_i & (~full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (wr_en_i && !wr_ok) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is intentionally not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o    = empty;
  assign full_o     = full;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/formula_result_buffer.sv
// Credit-gated front end for the non-stallable formula pipeline: issues a
// triple only when a result slot is reserved, and buffers every result.
module formula_result_buffer
  import formula_result_buffer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input logic                    clk,
  input logic                    rst,
  formula_result_buffer_if.slave bus
);

  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_rdy;
  logic             issue;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_overflow;
  logic [WIDTH-1:0] fifo_data;

  // Credit is decoded from the register alone so out_rdy never reaches in_rdy.
  assign in_rdy = (cnt_q != CW'(DEPTH));
  assign issue  = bus.in_vld & in_rdy;
  assign pop    = ~fifo_empty & bus.out_rdy;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({issue, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  result_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_result_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (bus.res_vld),
    .wr_data_i  (bus.res),
    .rd_en_i    (bus.out_rdy),
    .rd_data_o  (fifo_data),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .overflow_o (fifo_overflow)
  );

  assign bus.in_rdy   = in_rdy;
  assign bus.arg_vld  = issue;
  assign bus.out_vld  = ~fifo_empty;
  assign bus.out_data = fifo_data;
  assign bus.overflow = fifo_overflow;

endmodule

// File: tb/tb_formula_result_buffer.sv
// Directed bench for formula_result_buffer at DEPTH=4 with a fixed-latency pipeline stand-in.
module tb_formula_result_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  logic pipe_en;
  logic man_vld;
  logic [WIDTH-1:0] man_res;

  int n_cmp;
  int n_err;

  formula_result_buffer_if #(.WIDTH(WIDTH)) bus ();

  formula_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for formula_2_pipe: latency 3, results taken from a hand-computed table
  // ((4,12,16) -> 2, (0,0,0) -> 0), reset together with the buffer.
  logic [2:0]       pv;
  logic [WIDTH-1:0] pd [3];
  logic [WIDTH-1:0] exp_tab [4];
  int               issue_idx;

  initial begin
    exp_tab[0] = 32'd2;
    exp_tab[1] = 32'd0;
    exp_tab[2] = 32'd2;
    exp_tab[3] = 32'd0;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv        <= '0;
      issue_idx <= 0;
    end else begin
      pv    <= {pv[1:0], bus.arg_vld & pipe_en};
      pd[0] <= exp_tab[issue_idx[1:0]];
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      if (bus.arg_vld && pipe_en) issue_idx <= issue_idx + 1;
    end
  end

  assign bus.res_vld = pipe_en ? pv[2] : man_vld;
  assign bus.res     = pipe_en ? pd[2] : man_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  int pulses;
  int got;
  int seen;
  logic [WIDTH-1:0] rcv [2];
  logic [WIDTH-1:0] drain_exp [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    pipe_en = 1'b0;
    man_vld = 1'b0;
    man_res = '0;
    bus.in_vld = 1'b0;
    bus.out_rdy = 1'b0;
    drain_exp[0] = 32'd12;
    drain_exp[1] = 32'd13;
    drain_exp[2] = 32'd14;
    drain_exp[3] = 32'd20;

    // Reset state
    @(negedge clk); #1;
    chk("rst_in_rdy", bus.in_rdy, 1);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_arg_vld_lo", bus.arg_vld, 0);
    bus.in_vld = 1'b1; #1;
    chk("rst_arg_vld_hi", bus.arg_vld, 1);
    bus.in_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Credit exhaustion
    bus.in_vld = 1'b1;
    pulses = 0;
    repeat (6) begin
      #1;
      if (bus.arg_vld) pulses++;
      @(negedge clk);
    end
    #1;
    chk("credit_pulses", pulses, 4);
    chk("credit_in_rdy_lo", bus.in_rdy, 0);
    chk("credit_arg_vld_lo", bus.arg_vld, 0);
    bus.in_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      man_vld = 1'b1;
      man_res = WIDTH'(10 + i);
      @(negedge clk);
    end
    man_vld = 1'b0;
    bus.out_rdy = 1'b1; #1;
    chk("pop_out_vld", bus.out_vld, 1);
    chk("pop_data", bus.out_data, 10);
    chk("pop_in_rdy_still_lo", bus.in_rdy, 0);
    @(negedge clk);
    bus.out_rdy = 1'b0; #1;
    chk("pop_in_rdy_back", bus.in_rdy, 1);
    bus.in_vld = 1'b1; #1;
    chk("reissue_arg_vld", bus.arg_vld, 1);
    @(negedge clk); #1;
    chk("reissue_in_rdy_lo", bus.in_rdy, 0);
    bus.in_vld = 1'b0;

    // Fill to full, then push and pop in the same cycle across the wrap
    man_vld = 1'b1;
    man_res = 32'd14;
    @(negedge clk);
    man_vld = 1'b1;
    man_res = 32'd20;
    bus.out_rdy = 1'b1; #1;
    chk("full_pp_head", bus.out_data, 11);
    @(negedge clk);
    man_vld = 1'b0;
    bus.out_rdy = 1'b0; #1;
    chk("full_pp_no_ovf", bus.overflow, 0);
    chk("full_pp_new_head", bus.out_data, 12);

    // Overflow: full, no pop, value 9 must be dropped
    man_vld = 1'b1;
    man_res = 32'd9;
    @(negedge clk);
    man_vld = 1'b0; #1;
    chk("ovf_set", bus.overflow, 1);
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_vld", bus.out_vld, 1);
      chk("drain_data", bus.out_data, drain_exp[i]);
      @(negedge clk);
    end
    #1;
    chk("drain_empty", bus.out_vld, 0);
    chk("ovf_sticky", bus.overflow, 1);
    bus.out_rdy = 1'b0;
    do_reset();
    #1;
    chk("ovf_cleared", bus.overflow, 0);

    // Capture and order, no bypass
    bus.out_rdy = 1'b1;
    man_vld = 1'b1;
    man_res = 32'd5; #1;
    chk("cap_no_bypass", bus.out_vld, 0);
    @(negedge clk);
    man_res = 32'd7; #1;
    chk("cap_vld", bus.out_vld, 1);
    chk("cap_d0", bus.out_data, 5);
    @(negedge clk);
    man_res = 32'hFFFF_FFFF; #1;
    chk("cap_d1", bus.out_data, 7);
    @(negedge clk);
    man_vld = 1'b0; #1;
    chk("cap_d2", bus.out_data, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    chk("cap_empty", bus.out_vld, 0);
    bus.out_rdy = 1'b0;
    do_reset();

    // End-to-end through the pipeline stand-in
    pipe_en = 1'b1;
    bus.out_rdy = 1'b1;
    bus.in_vld = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.in_vld = 1'b0;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.out_vld) begin
        if (got < 2) rcv[got] = bus.out_data;
        got++;
      end
      @(negedge clk);
    end
    chk("e2e_count", got, 2);
    chk("e2e_r0", rcv[0], 2);
    chk("e2e_r1", rcv[1], 0);

    // Reset with a result still in flight
    bus.in_vld = 1'b1;
    @(negedge clk);
    bus.in_vld = 1'b0;
    rst = 1'b0; #1;
    chk("mid_rst_in_rdy", bus.in_rdy, 1);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (10) begin
      #1;
      if (bus.out_vld) seen++;
      @(negedge clk);
    end
    chk("mid_rst_no_stale", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/formula_result_buffer.md
# formula_result_buffer

Credit-gated output buffer that sits directly downstream of the non-stallable `formula_2_pipe`. It admits argument triples into the pipeline only when a result slot is guaranteed, and captures every `res_vld`/`res` pulse into a FIFO. Results are presented to the consumer over a valid/ready handshake, so the fixed-latency pipeline never needs backpressure and no result is ever dropped.

## Interface
- `WIDTH`, 32: result data width.
- `DEPTH`, 8: FIFO entries and total credits; power of two, ≥ 2.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `in_vld`  in  1  source has an argument triple ready.
- `in_rdy`  out  1  a credit is available; the triple is issued on `in_vld & in_rdy`.
- `arg_vld`  out  1  drives the pipeline's `arg_vld`; equals `in_vld & in_rdy`.
- `res_vld`  in  1  result valid from the pipeline.
- `res`  in  WIDTH  result data from the pipeline.
- `out_vld`  out  1  the FIFO holds at least one result.
- `out_rdy`  in  1  the consumer accepts the head entry.
- `out_data`  out  WIDTH  head entry; meaningful only while `out_vld` is high.
- `overflow`  out  1  sticky error: a result arrived while the FIFO was full and was not popped that cycle.

## Operation
- Credit counter `cnt`, width $clog2(DEPTH+1), counts results in flight plus results stored.
  - +1 on issue (`arg_vld`).
  - −1 on pop (`out_vld & out_rdy`).
  - Unchanged when both happen in the same cycle.
- `in_rdy = (cnt != DEPTH)`. It is decoded from the register only, with no combinational path from `out_rdy`.
- FIFO write:
  - On `res_vld`, `res` is written at `wr_ptr` and `wr_ptr` advances.
  - The write is accepted when the FIFO is not full, or when it is full and popping in the same cycle.
- FIFO read: `out_data = mem[rd_ptr]`. On pop, `rd_ptr` advances.
- Pointers are log2(DEPTH)+1 bits, with an extra wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the wrap bits differ.
  - Pointers wrap naturally modulo 2·DEPTH.
- Overflow case: `res_vld` with the FIFO full and no pop.
  - The data is dropped and the pointers hold.
  - `overflow` is set and stays set until reset.
  - This case is unreachable when `arg_vld` is the only source feeding the pipeline.
- `res_vld` with an empty FIFO and `out_rdy` high: there is no bypass. The entry appears the next cycle.
- `arg_vld` is purely combinational, so the pipeline sees the issue in the same cycle as the handshake.

## Timing
- Reset values:
  - `cnt=0`, both pointers 0, `overflow=0`.
  - Therefore `in_rdy=1`, `out_vld=0`, `arg_vld=in_vld`.
  - `out_data` is undefined; the memory is not reset.
- Write to visible: `res_vld` in cycle t gives `out_vld=1` with that data in cycle t+1.
- Pop to credit: a pop in cycle t gives `in_rdy` high in cycle t+1 (when it was low).
- Sustained throughput of one issue per cycle requires the consumer to pop one per cycle. With `out_rdy` held high, results stream out one per cycle.
- Reset asserted mid-operation:
  - All state clears immediately (asynchronous).
  - Results still in flight in the pipeline must be discarded by the system. The pipeline is reset together with this block.
- Reset deassertion is synchronised externally. Nothing is required of the block beyond the asynchronous clear.

## Structure
- `formula_result_buffer_pkg` holds:
  - the localparam functions for pointer width and count width;
  - no typedefs beyond `logic [WIDTH-1:0]`.
- Sub-module `result_fifo` contains the memory, pointers, full/empty and overflow logic. It is parameterised by `WIDTH` and `DEPTH`.
- The top level contains the credit counter and the `in_rdy`/`arg_vld` gating, and instantiates `result_fifo`.

## Test plan
- **Reset:** during and after `rst=0`, `in_rdy=1`, `out_vld=0`, `overflow=0`. `arg_vld` follows `in_vld`.
- **Credit exhaustion** (`DEPTH=4`, `out_rdy=0`, `in_vld=1` held):
  - `arg_vld` pulses exactly 4 cycles, then `in_rdy=0`.
  - One pop brings `in_rdy=1` the next cycle, and one more issue follows.
- **Capture and order:** `res_vld` with values 5, 7, 0xFFFFFFFF on consecutive cycles.
  - `out_vld` rises the cycle after the first write.
  - With `out_rdy=1`, `out_data` is 5, 7, 0xFFFFFFFF on three consecutive cycles.
- **Simultaneous push/pop when full** (`DEPTH=4`, full): `res_vld` and `out_rdy` in the same cycle.
  - The write is accepted and `overflow` stays 0.
  - Occupancy stays 4 and the data order is preserved across the pointer wrap.
- **Overflow:** FIFO full, `out_rdy=0`, force `res_vld` with value 9.
  - `overflow=1` from the next cycle and stays set.
  - Value 9 never appears on `out_data`.
- **End-to-end with `formula_2_pipe`:** issue (a=4, b=12, c=16), then (0, 0, 0), with `out_rdy=1`.
  - Expected output sequence: 2, then 0.
  - Also assert `rst` mid-stream: no stale result appears after reset.
